ram_loop_ctrl: RTL

Self-test sequencer for the 32 x 8 dual-port RAM. On a start pulse it drives the RAM write port through a full address sweep with a deterministic pattern. It then drives the read port through the same sweep and compares each returned word against the expected pattern, compensating for the RAM read latency. It reports busy, done, pass, the error count and the first failing address, and sits between the board control logic (key or top-level trigger) and the RAM IP instance.

---
 rtl/ram_loop_pkg.sv | 18 +
 rtl/ram_rd_chk.sv | 66 ++++++
 rtl/ram_loop_ctrl.sv | 119 +++++++++++
 3 files changed

// File: rtl/ram_loop_pkg.sv
// Shared types and default geometry for the RAM loop self-test sequencer.
// Imported by the controller and the read checker.
package ram_loop_pkg;

  localparam int DEF_DEPTH  = 32;
  localparam int DEF_AW     = 5;
  localparam int DEF_DW     = 8;
  localparam int DEF_RD_LAT = 2;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    READ,
    DRAIN,
    DONE
  } state_e;

endpackage

// File: rtl/ram_rd_chk.sv
// Read-latency shift line plus comparator for the RAM loop test.
// Tracks the mismatch count and the first failing address of a run.
module ram_rd_chk
  import ram_loop_pkg::*;
#(
  parameter int AW     = DEF_AW,
  parameter int DW     = DEF_DW,
  parameter int RD_LAT = DEF_RD_LAT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_i,
  input  logic          push_i,
  input  logic [AW-1:0] push_addr_i,
  input  logic [DW-1:0] pat_i,
  input  logic [DW-1:0] rd_data_i,
  output logic [AW:0]   err_cnt_o,
  output logic [AW-1:0] first_err_o,
  output logic          err_zero_d_o
);

  logic [RD_LAT-1:0] vld_q;
  logic [AW-1:0]     adr_q [RD_LAT];
  logic [AW:0]       err_q, err_d;
  logic [AW-1:0]     first_q, first_d;
  logic [DW-1:0]     exp_w;
  logic              miss;

  assign exp_w = pat_i + DW'(adr_q[RD_LAT-1]);
  assign miss  = vld_q[RD_LAT-1] && (rd_data_i != exp_w);

  always_comb begin
    err_d   = err_q;
    first_d = first_q;
    if (clr_i) begin
      err_d   = '0;
      first_d = '0;
    end else if (miss) begin
      if (err_q == '0) first_d = adr_q[RD_LAT-1];
      if (err_q != '1) err_d = err_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q   <= '0;
      err_q   <= '0;
      first_q <= '0;
      for (int i = 0; i < RD_LAT; i++) adr_q[i] <= '0;
    end else begin
      vld_q[0] <= push_i;
      adr_q[0] <= push_addr_i;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        adr_q[i] <= adr_q[i-1];
      end
      err_q   <= err_d;
      first_q <= first_d;
    end
  end

  assign err_cnt_o    = err_q;
  assign first_err_o  = first_q;
  assign err_zero_d_o = (err_d == '0);

endmodule

// File: rtl/ram_loop_ctrl.sv
// Self-test sequencer: write sweep, read sweep, latency-compensated compare.
// Reports busy/done/pass, error count and first failing address.
module ram_loop_ctrl
  import ram_loop_pkg::*;
#(
  parameter int DEPTH  = DEF_DEPTH,
  parameter int AW     = DEF_AW,
  parameter int DW     = DEF_DW,
  parameter int RD_LAT = DEF_RD_LAT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [DW-1:0] pat_base,
  output logic          ram_wr_en,
  output logic [AW-1:0] ram_wr_addr,
  output logic [DW-1:0] ram_wr_data,
  output logic          ram_rd_en,
  output logic [AW-1:0] ram_rd_addr,
  input  logic [DW-1:0] ram_rd_data,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic [AW:0]   err_cnt,
  output logic [AW-1:0] first_err_addr
);

  localparam logic [AW:0] LAST  = (AW+1)'(DEPTH - 1);
  localparam logic [AW:0] DLAST = (AW+1)'(RD_LAT - 1);

  state_e        state_q, state_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic [DW-1:0] pat_q;
  logic          pass_q;
  logic          accept;
  logic          err_zero_d;

  assign accept = start && (state_q == IDLE || state_q == DONE);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE, DONE: begin
        state_d = accept ? WRITE : IDLE;
        cnt_d   = '0;
      end
      WRITE: begin
        if (cnt_q == LAST) begin
          state_d = READ;
          cnt_d   = '0;
        end else cnt_d = cnt_q + 1'b1;
      end
      READ: begin
        if (cnt_q == LAST) begin
          state_d = DRAIN;
          cnt_d   = '0;
        end else cnt_d = cnt_q + 1'b1;
      end
      DRAIN: begin
        if (cnt_q == DLAST) begin
          state_d = DONE;
          cnt_d   = '0;
        end else cnt_d = cnt_q + 1'b1;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pat_q   <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        pat_q  <= pat_base;
        pass_q <= 1'b0;
      end else if (state_q == DRAIN && cnt_q == DLAST) begin
        // last compare of the run lands in this cycle; include it
        pass_q <= err_zero_d;
      end
    end
  end

  assign ram_wr_en   = (state_q == WRITE);
  assign ram_wr_addr = ram_wr_en ? cnt_q[AW-1:0] : '0;
  assign ram_wr_data = ram_wr_en ? pat_q + DW'(cnt_q[AW-1:0]) : '0;
  assign ram_rd_en   = (state_q == READ);
  assign ram_rd_addr = ram_rd_en ? cnt_q[AW-1:0] : '0;
  assign busy = (state_q == WRITE) || (state_q == READ)
             || (state_q == DRAIN);
  assign done = (state_q == DONE);
  assign pass = pass_q;

  ram_rd_chk #(
    .AW    (AW),
    .DW    (DW),
    .RD_LAT(RD_LAT)
  ) u_chk (
    .clk         (clk),
    .rst         (rst),
    .clr_i       (accept),
    .push_i      (ram_rd_en),
    .push_addr_i (cnt_q[AW-1:0]),
    .pat_i       (pat_q),
    .rd_data_i   (ram_rd_data),
    .err_cnt_o   (err_cnt),
    .first_err_o (first_err_addr),
    .err_zero_d_o(err_zero_d)
  );

endmodule
